usb_data_tx: RTL and testbench
==============================

Name: usb_data_tx

Overview:
- Packet-level transmit sequencer for USB DATA packets.
- Sits directly upstream of the crc16 engine and owns the full start/stream/receive handshake with it.
- Accepts a PID byte and a 64-bit payload, then emits one serial bitstream: PID, then payload, then the 16 CRC bits returned by crc16.
- The stream goes to the downstream bit-stuff/NRZI stage.

Parameters:
- PID_BITS, 8: PID field length in bits.
- DATA_BITS, 64: payload length in bits; must equal the crc16 data-phase length.
- CRC_BITS, 16: number of CRC bits to forward.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pkt_req  in  1  request to send a packet; level, held until pkt_ack.
- pid  in  PID_BITS  PID; sampled in the cycle pkt_ack=1.
- data  in  DATA_BITS  payload; sampled in the cycle pkt_ack=1.
- pkt_ack  out  1  one-cycle pulse: request accepted, inputs latched.
- busy  out  1  high from the cycle after pkt_ack through the pkt_done cycle.
- tx_bit  out  1  serial output bit.
- tx_valid  out  1  tx_bit is a packet bit this cycle.
- tx_sop  out  1  first PID bit, coincident with tx_valid.
- tx_eop  out  1  last CRC bit, coincident with tx_valid.
- pkt_done  out  1  one-cycle pulse: packet complete, block returns to IDLE.
- crc_start  out  1  to crc16 crc16_start; one-cycle pulse.
- crc_bit  out  1  to crc16 s_in; payload bit feeding the CRC.
- crc_rec  out  1  to crc16 crc16_rec; one-cycle acknowledge.
- crc_in  in  1  from crc16 crc16_out.
- crc_ready  in  1  from crc16 crc16_ready; crc_in is valid.
- crc_done  in  1  from crc16 crc16_done.

Behaviour:
- Reset: state=IDLE; all outputs 0; pid/data shift registers and bit counter cleared.
- Reset mid-packet aborts immediately with no flush. The crc16 engine shares rst_n, so both return to idle together.
- FSM states: IDLE, PID, DATA, GAP, CRC, WAIT.
- IDLE:
  - If pkt_req=1: pkt_ack=1, latch pid/data, clear counter, next state PID.
  - Otherwise stay in IDLE.
  - A pkt_req arriving while busy is not acknowledged until the block is back in IDLE. Re-acceptance happens no earlier than the cycle after pkt_done.
- PID:
  - tx_valid=1, tx_bit=pid shift register LSB (LSB first); shift right each cycle.
  - tx_sop=1 on count 0.
  - On count PID_BITS-1: crc_start=1, clear counter, next state DATA.
  - The PID never enters the CRC.
- DATA:
  - tx_valid=1, tx_bit=crc_bit=data shift register LSB (LSB first); shift each cycle.
  - Exactly DATA_BITS consecutive cycles, beginning the cycle after crc_start.
  - After count DATA_BITS-1: next state GAP.
- GAP: one cycle, tx_valid=0. This covers the crc16 complement-load cycle. Next state CRC.
- CRC:
  - tx_valid=crc_ready, tx_bit=crc_in; tx_bit=0 when crc_ready=0.
  - Count cycles with crc_ready=1. On the CRC_BITS-th such cycle: tx_eop=1, next state WAIT.
  - Cycles with crc_ready=0 in this state emit nothing and are not counted.
- WAIT:
  - Hold until crc_done=1.
  - In that cycle: crc_rec=1 and pkt_done=1 (same cycle), next state IDLE.
  - If crc_done is already high on entry, the exit happens on the first WAIT cycle.
- crc_bit is 0 outside DATA. crc_start and crc_rec are never high simultaneously.
- No stall input: once accepted, a packet streams to completion. The downstream stage must absorb one bit per cycle.
- Nominal timing with crc16, taking the pkt_ack cycle as cycle 0:
  - PID on cycles 1-8; crc_start on cycle 8.
  - Payload on cycles 9-72; GAP on cycle 73.
  - CRC on cycles 74-89; tx_eop on cycle 89.
  - crc_done, crc_rec and pkt_done on cycle 91.
  - pkt_ack for the next packet no earlier than cycle 92.
- Total tx_valid cycles per packet = PID_BITS+DATA_BITS+CRC_BITS = 88.

Test Plan:
1. Reset, then pkt_req with pid=8'hC3, data=64'h0123_4567_89AB_CDEF, bench crc16 model -> pkt_ack at cycle 0; tx bits 1-8 = 1,1,0,0,0,0,1,1; payload bits LSB first (first bit 1); crc_start only at cycle 8; crc_bit mirrors the 64 payload bits; 88 valid bits total; tx_sop/tx_eop each exactly once.
2. Same packet with the real crc16 instance -> 16 CRC bits on tx_bit match crc16_out; crc_rec at cycle 91; crc16 back in INIT afterwards.
3. Bench crc model inserts 3 crc_ready=0 cycles mid-CRC and delays crc_done by 5 cycles -> no tx_valid gaps counted; tx_eop on the 16th ready bit; crc_rec/pkt_done wait for crc_done.
4. pkt_req held high continuously with a new pid each packet (8'h4B, 8'hC3) -> second pkt_ack exactly one cycle after pkt_done; second packet uses values latched at its own ack.
5. rst_n asserted at cycle 40 (mid-payload) -> all outputs 0 in the same cycle; after release, a fresh request completes a correct 88-bit packet.
6. pkt_req toggled during busy -> no extra pkt_ack; latched pid/data remain unchanged.

Source files
------------

// File: rtl/usb_data_tx_if.sv
// -----------------------------------------------------------------------------
// usb_data_tx_if
//   Bundles the packet request side, the serial transmit stream and the crc16
//   handshake of the USB DATA packet transmitter into one interface.
//
//   Signals
//     pkt_req / pid / data        : packet request and its contents
//     pkt_ack / busy / pkt_done   : request accepted, in progress, complete
//     tx_bit / tx_valid           : serial stream towards bit-stuff/NRZI
//     tx_sop / tx_eop             : first PID bit / last CRC bit markers
//     crc_start / crc_bit / crc_rec : towards crc16
//     crc_in / crc_ready / crc_done : from crc16
//
//   Modports
//     slave  : the transmitter itself (usb_data_tx)
//     master : its environment (packet source, stream sink, crc16 engine)
// -----------------------------------------------------------------------------
interface usb_data_tx_if #(
    parameter int PID_BITS  = 8,
    parameter int DATA_BITS = 64
);
    logic                 pkt_req;
    logic [PID_BITS-1:0]  pid;
    logic [DATA_BITS-1:0] data;
    logic                 pkt_ack;
    logic                 busy;
    logic                 tx_bit;
    logic                 tx_valid;
    logic                 tx_sop;
    logic                 tx_eop;
    logic                 pkt_done;
    logic                 crc_start;
    logic                 crc_bit;
    logic                 crc_rec;
    logic                 crc_in;
    logic                 crc_ready;
    logic                 crc_done;

    modport slave (
        input  pkt_req, pid, data, crc_in, crc_ready, crc_done,
        output pkt_ack, busy, tx_bit, tx_valid, tx_sop, tx_eop, pkt_done,
               crc_start, crc_bit, crc_rec
    );

    modport master (
        output pkt_req, pid, data, crc_in, crc_ready, crc_done,
        input  pkt_ack, busy, tx_bit, tx_valid, tx_sop, tx_eop, pkt_done,
               crc_start, crc_bit, crc_rec
    );
endinterface

// File: rtl/usb_data_tx.sv
// -----------------------------------------------------------------------------
// usb_data_tx
//   Transmit sequencer for USB DATA packets. Accepts a PID and a payload,
//   then emits one serial stream: PID (LSB first), payload (LSB first, also
//   fed bit by bit into crc16), then the CRC bits returned by crc16.
//
//   Ports
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset (shared with crc16)
//     bus   : usb_data_tx_if.slave -- request, serial stream, crc16 handshake
//
//   Sequence: IDLE -> PID -> DATA -> GAP -> CRC -> WAIT -> IDLE
// -----------------------------------------------------------------------------
module usb_data_tx #(
    parameter int PID_BITS  = 8,
    parameter int DATA_BITS = 64,
    parameter int CRC_BITS  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    usb_data_tx_if.slave  bus
);

    // One counter serves all three fields, so size it for the longest one.
    localparam int MAX_BITS = (DATA_BITS > PID_BITS)
                            ? ((DATA_BITS > CRC_BITS) ? DATA_BITS : CRC_BITS)
                            : ((PID_BITS  > CRC_BITS) ? PID_BITS  : CRC_BITS);
    localparam int CNT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

    localparam logic [CNT_W-1:0] PID_LAST  = CNT_W'(PID_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_DATA,
        S_GAP,
        S_CRC,
        S_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [PID_BITS-1:0]  pid_q,   pid_d;
    logic [DATA_BITS-1:0] data_q,  data_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value; the shift registers are plain flops (not a RAM), so
    // they are cleared by reset along with the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pid_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pid_q   <= pid_d;
            data_q  <= data_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pid_d         = pid_q;
        data_d        = data_q;
        bus.pkt_ack   = 1'b0;
        bus.busy      = (state_q != S_IDLE);
        bus.tx_bit    = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_sop    = 1'b0;
        bus.tx_eop    = 1'b0;
        bus.pkt_done  = 1'b0;
        bus.crc_start = 1'b0;
        bus.crc_bit   = 1'b0;
        bus.crc_rec   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.pkt_req) begin
                    bus.pkt_ack = 1'b1;
                    pid_d       = bus.pid;
                    data_d      = bus.data;
                    cnt_d       = '0;
                    state_d     = S_PID;
                end
            end

            S_PID: begin
                bus.tx_valid = 1'b1;
                bus.tx_bit   = pid_q[0];
                bus.tx_sop   = (cnt_q == '0);
                pid_d        = pid_q >> 1;
                cnt_d        = cnt_q + CNT_ONE;
                // crc16 is started on the last PID bit so its data phase lines
                // up with the first payload bit on the next cycle.
                if (cnt_q == PID_LAST) begin
                    bus.crc_start = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_DATA;
                end
            end

            S_DATA: begin
                bus.tx_valid = 1'b1;
                bus.tx_bit   = data_q[0];
                bus.crc_bit  = data_q[0];
                data_d       = data_q >> 1;
                cnt_d        = cnt_q + CNT_ONE;
                if (cnt_q == DATA_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end

            // Idle slot while crc16 loads its complemented remainder.
            S_GAP: begin
                state_d = S_CRC;
            end

            // Forward CRC bits only while crc16 flags them ready; stalled
            // cycles neither emit nor count.
            S_CRC: begin
                bus.tx_valid = bus.crc_ready;
                bus.tx_bit   = bus.crc_ready & bus.crc_in;
                if (bus.crc_ready) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CRC_LAST) begin
                        bus.tx_eop = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (bus.crc_done) begin
                    bus.crc_rec  = 1'b1;
                    bus.pkt_done = 1'b1;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_data_tx.sv
// -----------------------------------------------------------------------------
// tb_usb_data_tx
//   Directed bench for usb_data_tx. A small crc16 stand-in captures crc_bit,
//   returns a fixed 16-bit pattern (optionally with stall cycles) and raises
//   crc_done after a configurable delay. Inputs change 1 ns after the rising
//   edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_usb_data_tx;

    localparam int PID_BITS  = 8;
    localparam int DATA_BITS = 64;
    localparam int CRC_BITS  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    usb_data_tx_if #(.PID_BITS(PID_BITS), .DATA_BITS(DATA_BITS)) bus ();

    usb_data_tx #(
        .PID_BITS (PID_BITS),
        .DATA_BITS(DATA_BITS),
        .CRC_BITS (CRC_BITS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // crc16 stand-in
    int          m_ph = 0;          // 0 idle,1 data,2 load,3 crc,4 delay,5 done
    int          m_cnt, m_idx, m_w, m_stalled;
    logic        m_rdy = 1'b0;
    logic [63:0] m_data = '0;
    logic [15:0] cfg_pat = 16'hB4E1;
    int          cfg_stall_at = -1;
    int          cfg_nstall   = 0;
    int          cfg_extra    = 0;

    // expectation tracker
    logic        c_act  = 1'b0;
    logic        c_post = 1'b0;
    int          k      = 0;
    int          c_nr   = 0;
    logic [7:0]  e_pid  = '0;
    logic [63:0] e_data = '0;
    int          g_cyc = 0, ack_cyc = 0, done_cyc = 0;
    int          n_pkts = 0, n_ack = 0;
    int          p_valid, p_sop, p_eop, p_start, p_done_k;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_model();
        m_rdy         = (m_ph == 3) && !(m_idx == cfg_stall_at && m_stalled < cfg_nstall);
        bus.crc_ready = m_rdy;
        // During stalls crc_in carries junk that must not reach tx_bit.
        bus.crc_in    = m_rdy ? cfg_pat[m_idx] : (m_ph == 3);
        bus.crc_done  = (m_ph == 5);
    endtask

    function automatic logic [9:0] obs_vec();
        return {bus.pkt_ack, bus.busy, bus.tx_valid, bus.tx_bit, bus.tx_sop,
                bus.tx_eop, bus.crc_start, bus.crc_bit, bus.crc_rec, bus.pkt_done};
    endfunction

    task automatic sample();
        logic [9:0] exp;
        exp = '0;
        if (rst_n) begin
            if (!c_act) begin
                exp[9] = bus.pkt_req;
            end else begin
                exp[8] = 1'b1;
                if (k <= PID_BITS) begin
                    exp[7] = 1'b1;
                    exp[6] = e_pid[k-1];
                    exp[5] = (k == 1);
                    exp[3] = (k == PID_BITS);
                end else if (k <= PID_BITS + DATA_BITS) begin
                    exp[7] = 1'b1;
                    exp[6] = e_data[k-PID_BITS-1];
                    exp[2] = e_data[k-PID_BITS-1];
                end else if (k >= PID_BITS + DATA_BITS + 2 && !c_post) begin
                    exp[7] = m_rdy;
                    exp[6] = m_rdy & cfg_pat[c_nr];
                    exp[4] = m_rdy && (c_nr == CRC_BITS - 1);
                end else if (c_post) begin
                    exp[1] = bus.crc_done;
                    exp[0] = bus.crc_done;
                end
            end
        end
        check($sformatf("cyc%0d_k%0d", g_cyc, k), obs_vec(), exp);

        if (bus.pkt_ack) n_ack++;

        if (!rst_n) begin
            c_act = 1'b0;
        end else if (!c_act) begin
            if (bus.pkt_req) begin
                c_act    = 1'b1;
                c_post   = 1'b0;
                k        = 1;
                c_nr     = 0;
                e_pid    = bus.pid;
                e_data   = bus.data;
                ack_cyc  = g_cyc;
                p_valid  = 0; p_sop = 0; p_eop = 0; p_start = 0; p_done_k = -1;
            end
        end else begin
            p_valid += int'(bus.tx_valid);
            p_sop   += int'(bus.tx_sop);
            p_eop   += int'(bus.tx_eop);
            p_start += int'(bus.crc_start);
            if (c_post) begin
                if (bus.crc_done) begin
                    c_act    = 1'b0;
                    p_done_k = k;
                    done_cyc = g_cyc;
                    n_pkts++;
                end
            end else if (k >= PID_BITS + DATA_BITS + 2 && m_rdy) begin
                c_nr++;
                if (c_nr == CRC_BITS) c_post = 1'b1;
            end
            k++;
        end

        // crc16 stand-in reacts to what it saw this cycle
        if (!rst_n) begin
            m_ph = 0;
        end else begin
            case (m_ph)
                0: if (bus.crc_start) begin m_ph = 1; m_cnt = 0; end
                1: begin
                    m_data[m_cnt] = bus.crc_bit;
                    m_cnt++;
                    if (m_cnt == DATA_BITS) m_ph = 2;
                end
                2: begin m_ph = 3; m_idx = 0; m_stalled = 0; end
                3: begin
                    if (m_rdy) begin
                        m_idx++;
                        if (m_idx == CRC_BITS) begin m_ph = 4; m_w = 1 + cfg_extra; end
                    end else begin
                        m_stalled++;
                    end
                end
                4: begin m_w--; if (m_w == 0) m_ph = 5; end
                5: if (bus.crc_rec) m_ph = 0;
                default: m_ph = 0;
            endcase
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        g_cyc++;
        @(posedge clk);
        #1;
        drive_model();
    endtask

    task automatic send(input logic [7:0] p, input logic [63:0] d, input logic hold);
        int i;
        i = 0;
        bus.pkt_req = 1'b1;
        bus.pid     = p;
        bus.data    = d;
        while (!c_act && i < 20) begin step(); i++; end
        check("ack_seen", c_act, 1);
        bus.pkt_req = hold;
    endtask

    task automatic wait_done(input int budget);
        int n0, i;
        n0 = n_pkts;
        i  = 0;
        while (n_pkts == n0 && i < budget) begin step(); i++; end
        check("pkt_done_seen", n_pkts - n0, 1);
    endtask

    task automatic check_pkt(input string t, input int done_k, input logic [63:0] d);
        check({t, "_valid_bits"}, p_valid, PID_BITS + DATA_BITS + CRC_BITS);
        check({t, "_sop_count"},  p_sop,   1);
        check({t, "_eop_count"},  p_eop,   1);
        check({t, "_start_count"}, p_start, 1);
        check({t, "_done_cycle"}, p_done_k, done_k);
        check({t, "_crc_payload"}, m_data, d);
    endtask

    initial begin
        int n0;
        bus.pkt_req = 1'b0;
        bus.pid     = '0;
        bus.data    = '0;
        drive_model();

        // Reset state: every output low.
        step();
        step();
        check("reset_outputs", obs_vec(), 0);
        rst_n = 1'b1;
        step();

        // 1: nominal packet
        send(8'hC3, 64'h0123_4567_89AB_CDEF, 1'b0);
        wait_done(200);
        check_pkt("t1", 91, 64'h0123_4567_89AB_CDEF);

        // 2: second nominal packet, different CRC pattern; crc side idle after
        cfg_pat = 16'h3A5C;
        step();
        send(8'h69, 64'hFEDC_BA98_7654_3210, 1'b0);
        wait_done(200);
        check_pkt("t2", 91, 64'hFEDC_BA98_7654_3210);
        step();
        check("t2_crc_idle", m_ph, 0);

        // 3: three stall cycles mid-CRC, crc_done five cycles late
        cfg_stall_at = 7;
        cfg_nstall   = 3;
        cfg_extra    = 5;
        send(8'hA5, 64'h8000_0000_0000_0001, 1'b0);
        wait_done(200);
        check_pkt("t3", 99, 64'h8000_0000_0000_0001);
        cfg_stall_at = -1;
        cfg_nstall   = 0;
        cfg_extra    = 0;
        step();

        // 4: pkt_req held high across two packets
        send(8'h4B, 64'h1111_2222_3333_4444, 1'b1);
        bus.pid  = 8'hC3;
        bus.data = 64'h5555_6666_7777_8888;
        wait_done(200);
        check_pkt("t4a", 91, 64'h1111_2222_3333_4444);
        step();
        check("t4_reack_gap", ack_cyc - done_cyc, 1);
        bus.pkt_req = 1'b0;
        wait_done(200);
        check_pkt("t4b", 91, 64'h5555_6666_7777_8888);
        step();

        // 5: reset mid-payload, then a fresh packet
        send(8'h5A, 64'hA5A5_0F0F_3C3C_9696, 1'b0);
        while (c_act && k < 40) step();
        rst_n = 1'b0;
        #1;
        check("t5_reset_outputs", obs_vec(), 0);
        step();
        rst_n = 1'b1;
        step();
        send(8'hE1, 64'h0F1E_2D3C_4B5A_6978, 1'b0);
        wait_done(200);
        check_pkt("t5", 91, 64'h0F1E_2D3C_4B5A_6978);
        step();

        // 6: pkt_req and inputs toggled while busy
        n0 = n_ack;
        send(8'h96, 64'h1357_9BDF_2468_ACE0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            bus.pkt_req = i[0];
            bus.pid     = 8'($urandom);
            bus.data    = {$urandom, $urandom};
            step();
        end
        bus.pkt_req = 1'b0;
        wait_done(200);
        check_pkt("t6", 91, 64'h1357_9BDF_2468_ACE0);
        check("t6_ack_count", n_ack - n0, 1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
